// File: rtl/seq_pkg.sv
// Shared types and defaults for the sequence-detection front end:
// the serializer FSM state encoding and the default word geometry.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int   SEQ_WORD_W   = 8;
  localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: takes WIDTH-bit words over valid/ready and emits
// them one bit per clock, back-to-back words streaming with no idle gap.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_WORD_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SEQ_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             at_last;
  logic             accept;

  // Bit that goes on the wire next, and the word left once it has been sent.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? (word << 1) : (word >> 1);
  endfunction

  // The final bit of a word is on the wire: a new word may be loaded behind it.
  assign at_last  = (state == SER_SHIFT) && (bit_cnt == LAST_CNT);
  assign in_ready = !flush && ((state == SER_IDLE) || at_last);
  assign accept   = in_valid && in_ready;
  assign busy     = out_valid;

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SER_IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      out_bit   <= IDLE_BIT;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      // Abort wins over any handshake offered in the same cycle.
      state     <= SER_IDLE;
      bit_cnt   <= '0;
      out_bit   <= IDLE_BIT;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (accept) begin
            state     <= SER_SHIFT;
            shift_q   <= advance(in_data);
            bit_cnt   <= '0;
            out_bit   <= head_bit(in_data);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        SER_SHIFT: begin
          if (!at_last) begin
            shift_q  <= advance(shift_q);
            bit_cnt  <= bit_cnt + 1'b1;
            out_bit  <= head_bit(shift_q);
            out_last <= (bit_cnt == LAST_CNT - 1'b1);
          end else if (accept) begin
            shift_q   <= advance(in_data);
            bit_cnt   <= '0;
            out_bit   <= head_bit(in_data);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            state     <= SER_IDLE;
            bit_cnt   <= '0;
            out_bit   <= IDLE_BIT;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Scoreboarded bench: an MSB-first and an LSB-first serializer share one
// stimulus stream; a queue-based stream model predicts every output cycle.
module tb_seq_bit_serializer;

  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;

  logic in_ready_m, out_bit_m, out_valid_m, out_last_m, busy_m;
  logic in_ready_l, out_bit_l, out_valid_l, out_last_l, busy_l;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {bit, last} entries still to appear on each serial output.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  // Bits of the in-flight word not yet presented after the current one.
  int pend = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_msb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .flush(flush), .out_bit(out_bit_m),
    .out_valid(out_valid_m), .out_last(out_last_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .flush(flush), .out_bit(out_bit_l),
    .out_valid(out_valid_l), .out_last(out_last_l), .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_lane(input string tag, input logic v, input logic b, input logic l,
                            input logic bz, input logic has, input logic [1:0] e);
    check({tag, "_valid"}, 32'(v), 32'(has));
    check({tag, "_busy"}, 32'(bz), 32'(has));
    if (has) begin
      check({tag, "_bit"}, 32'(b), 32'(e[1]));
      check({tag, "_last"}, 32'(l), 32'(e[0]));
    end else begin
      check({tag, "_idle_bit"}, 32'(b), 32'(IDLE));
      check({tag, "_idle_last"}, 32'(l), 32'd0);
    end
  endtask

  // Reference model: a word is taken when nothing of the previous word remains
  // to be sent after the current bit; it then fills the stream queue.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_m.delete();
      q_l.delete();
      pend = 0;
    end else if (flush) begin
      q_m.delete();
      q_l.delete();
      pend = 0;
    end else if (in_valid && pend == 0) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back({in_data[W-1-i], (i == W - 1)});
        q_l.push_back({in_data[i], (i == W - 1)});
      end
      pend = W - 1;
    end else if (pend > 0) begin
      pend = pend - 1;
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    logic       has_m, has_l, exp_ready;
    logic [1:0] e_m, e_l;
    if (reset_n) begin
      exp_ready = !flush && (pend == 0);
      check("ready_msb", 32'(in_ready_m), 32'(exp_ready));
      check("ready_lsb", 32'(in_ready_l), 32'(exp_ready));
      has_m = (q_m.size() != 0);
      has_l = (q_l.size() != 0);
      e_m = 2'b00;
      e_l = 2'b00;
      if (has_m) e_m = q_m.pop_front();
      if (has_l) e_l = q_l.pop_front();
      check_lane("msb", out_valid_m, out_bit_m, out_last_m, busy_m, has_m, e_m);
      check_lane("lsb", out_valid_l, out_bit_l, out_last_l, busy_l, has_l, e_l);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic f);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    flush    = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset held for three cycles while upstream offers a word.
    in_valid = 1'b1;
    in_data  = 8'hB0;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(out_valid_m | out_valid_l), 32'd0);
      check("rst_bit", 32'(out_bit_m | out_bit_l), 32'(IDLE));
      check("rst_busy", 32'(busy_m | busy_l), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("post_rst_ready", 32'({in_ready_m, in_ready_l}), 32'b11);
    idle(2);

    // Single word, then back-to-back streaming, then LSB-first pattern.
    drive(1'b1, 8'hB0, 1'b0);
    idle(10);
    drive(1'b1, 8'hA5, 1'b0);
    repeat (8) drive(1'b1, 8'h3C, 1'b0);
    idle(10);
    drive(1'b1, 8'h0D, 1'b0);
    idle(10);

    // Flush while the third bit is on the wire; next word follows right after.
    drive(1'b1, 8'hFF, 1'b0);
    repeat (2) drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h69, 1'b0);
    idle(10);

    // Asynchronous reset pulse between edges in the middle of a word.
    drive(1'b1, 8'hC3, 1'b0);
    idle(3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'({out_valid_m, out_valid_l}), 32'd0);
    check("async_rst_bit", 32'({out_bit_m, out_bit_l}), 32'({IDLE, IDLE}));
    check("async_rst_busy", 32'({busy_m, busy_l}), 32'd0);
    #3;
    reset_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0);
    idle(10);

    // Randomised traffic with occasional flushes.
    repeat (400)
      drive(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom_range(0, 19) == 0));
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_seq_bit_serializer
